// File: rtl/ram_arbiter.sv
// ram_arbiter: zero-fills a shared RAM after reset or on clr, then grants one
// access per cycle to two requesters with round-robin arbitration. Read data
// is registered and returned one cycle after acceptance.
module ram_arbiter #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DWIDTH-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DWIDTH-1:0] rsp1_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [AWIDTH-1:0] mem_wraddr,
  output logic [DWIDTH-1:0] mem_wrdata,
  output logic              mem_we
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [AWIDTH-1:0] cnt;
  logic              last;
  logic              act;
  logic              gnt0;
  logic              gnt1;
  logic              rd0;
  logic              rd1;

  // Round-robin grant: on a tie the requester not granted last wins
  always_comb begin
    act  = ~rst & (state == RUN) & ~clr;
    gnt0 = act & req0_valid & (~req1_valid | last);
    gnt1 = act & req1_valid & (~req0_valid | ~last);
    rd0  = gnt0 & ~req0_we;
    rd1  = gnt1 & ~req1_we;
  end

  // RAM port steering: fill writes during CLEAR, otherwise the granted access
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wraddr = '0;
    mem_wrdata = '0;
    if (~rst && state == CLEAR) begin
      mem_we     = 1'b1;
      mem_wraddr = cnt;
    end else if (gnt0) begin
      if (req0_we) begin
        mem_we     = 1'b1;
        mem_wraddr = req0_addr;
        mem_wrdata = req0_wdata;
      end else begin
        mem_addr = req0_addr;
      end
    end else if (gnt1) begin
      if (req1_we) begin
        mem_we     = 1'b1;
        mem_wraddr = req1_addr;
        mem_wrdata = req1_wdata;
      end else begin
        mem_addr = req1_addr;
      end
    end
  end

  assign busy       = rst | (state == CLEAR);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Fill sequencing, arbitration pointer and registered read responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      last       <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= rd0;
      rsp1_valid <= rd1;
      if (rd0) rsp0_rdata <= mem_rdata;
      if (rd1) rsp1_rdata <= mem_rdata;
      if (gnt0)      last <= 1'b0;
      else if (gnt1) last <= 1'b1;
      case (state)
        CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + AWIDTH'(1);
            if (cnt == '1) state <= RUN;
          end
        end
        RUN: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: provides the RAM array and checks the arbiter
// against a transaction-level model of memory contents and grant order.
module tb_ram_arbiter;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          busy;
  logic          req0_valid, req1_valid, req0_we, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] mem_addr, mem_wraddr;
  logic [DW-1:0] mem_rdata, mem_wrdata;
  logic          mem_we;
  logic          scramble = 1'b0;

  logic [DW-1:0] ram [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_mem [DEPTH];
  int            exp_last;
  logic          exp_rv0, exp_rv1;
  logic [DW-1:0] exp_rd0, exp_rd1;

  always #5 clk = ~clk;

  // RAM array: asynchronous read, clocked write; scramble preloads garbage
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'($urandom);
    end else if (mem_we) begin
      ram[mem_wraddr] <= mem_wrdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wraddr(mem_wraddr),
    .mem_wrdata(mem_wrdata), .mem_we(mem_we)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr        = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  // Expected winner: sole valid requester, or on a tie the one not granted last
  function automatic int pick(logic v0, logic v1, int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    exp_last = 1;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    exp_rd0 = '0;   exp_rd1 = '0;
  endtask

  // Apply accepted transaction g (-1 = none) to the model, then clock
  task automatic step(int g);
    logic nrv0, nrv1;
    nrv0 = 1'b0;
    nrv1 = 1'b0;
    if (g == 0) begin
      exp_last = 0;
      if (req0_we) exp_mem[req0_addr] = req0_wdata;
      else begin nrv0 = 1'b1; exp_rd0 = exp_mem[req0_addr]; end
    end else if (g == 1) begin
      exp_last = 1;
      if (req1_we) exp_mem[req1_addr] = req1_wdata;
      else begin nrv1 = 1'b1; exp_rd1 = exp_mem[req1_addr]; end
    end
    exp_rv0 = nrv0;
    exp_rv1 = nrv1;
    tick();
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1; idle(); scramble = 1'b1;
    tick();
    scramble = 1'b0;
    req0_valid = 1'b1; req0_addr = AW'(9);
    tick();
    n_checks++;
    if ({busy, req0_ready, req1_ready, mem_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: busy/rdy0/rdy1/we=%b/%b/%b/%b expected 1/0/0/0", busy, req0_ready, req1_ready, mem_we);
    end
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: v0/v1/d0/d1=%b/%b/%h/%h expected all 0", rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata);
    end
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if ({busy, mem_we, mem_wraddr, mem_wrdata, req0_ready} !== {1'b1, 1'b1, AW'(i), DW'(0), 1'b0}) begin
        n_fail++;
        $display("FAIL fill_%0d: busy/we/wraddr/wrdata/rdy0=%b/%b/%0d/%0d/%b expected 1/1/%0d/0/0", i, busy, mem_we, mem_wraddr, mem_wrdata, req0_ready, i);
      end
      exp_mem[i] = '0;
      step(-1);
    end
    #1;
    n_checks++;
    if ({busy, req0_ready, mem_we, mem_addr} !== {1'b0, 1'b1, 1'b0, AW'(9)}) begin
      n_fail++;
      $display("FAIL run_entry: busy/rdy0/we/addr=%b/%b/%b/%0d expected 0/1/0/9", busy, req0_ready, mem_we, mem_addr);
    end
    g = pick(req0_valid, req1_valid, exp_last);
    step(g);
    idle();
    n_checks++;
    if ({rsp0_valid, rsp0_rdata} !== {1'b1, DW'(0)}) begin
      n_fail++;
      $display("FAIL read_after_fill: v/d=%b/%h expected 1/0", rsp0_valid, rsp0_rdata);
    end
  endtask

  task automatic test_single();
    idle();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = AW'(3); req0_wdata = DW'(4'hA);
    #1;
    n_checks++;
    if ({req0_ready, mem_we, mem_wraddr, mem_wrdata} !== {1'b1, 1'b1, AW'(3), DW'(4'hA)}) begin
      n_fail++;
      $display("FAIL single_wr: rdy/we/wraddr/wrdata=%b/%b/%0d/%h expected 1/1/3/a", req0_ready, mem_we, mem_wraddr, mem_wrdata);
    end
    step(0);
    req0_we = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(3)}) begin
      n_fail++;
      $display("FAIL single_rd: rdy/we/addr=%b/%b/%0d expected 1/0/3", req0_ready, mem_we, mem_addr);
    end
    step(0);
    idle();
    n_checks++;
    if ({rsp0_valid, rsp0_rdata} !== {1'b1, DW'(4'hA)}) begin
      n_fail++;
      $display("FAIL single_rsp: v/d=%b/%h expected 1/a", rsp0_valid, rsp0_rdata);
    end
    #1;
    n_checks++;
    if ({mem_we, mem_addr, mem_wraddr, mem_wrdata} !== '0) begin
      n_fail++;
      $display("FAIL idle_ports: we/addr/wraddr/wrdata=%b/%0d/%0d/%h expected 0/0/0/0", mem_we, mem_addr, mem_wraddr, mem_wrdata);
    end
    step(-1);
    n_checks++;
    if ({rsp0_valid, rsp0_rdata} !== {1'b0, DW'(4'hA)}) begin
      n_fail++;
      $display("FAIL single_hold: v/d=%b/%h expected 0/a", rsp0_valid, rsp0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    req1_valid = 1'b1; req1_addr = AW'(3);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_solo: rdy0/rdy1=%b/%b expected 0/1", req0_ready, req1_ready);
    end
    step(1);
    req0_valid = 1'b1; req0_addr = AW'(5);
    req1_addr = AW'(6);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_tie: rdy0/rdy1=%b/%b expected 1/0", req0_ready, req1_ready);
    end
    n_checks++;
    if ({rsp1_valid, rsp1_rdata} !== {1'b1, DW'(4'hA)}) begin
      n_fail++;
      $display("FAIL b2b_rsp1: v/d=%b/%h expected 1/a", rsp1_valid, rsp1_rdata);
    end
    step(0);
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_held: rdy0/rdy1=%b/%b expected 0/1", req0_ready, req1_ready);
    end
    step(1);
    idle();
  endtask

  task automatic test_contention();
    idle();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = AW'(1); req0_wdata = DW'($urandom);
    #1;
    step(pick(req0_valid, req1_valid, exp_last));
    idle();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = AW'(2); req1_wdata = DW'($urandom);
    #1;
    step(pick(req0_valid, req1_valid, exp_last));
    idle();
    req0_valid = 1'b1; req0_addr = AW'(1);
    req1_valid = 1'b1; req1_addr = AW'(2);
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL contend_%0d: rdy0/rdy1=%b/%b expected req%0d", k, req0_ready, req1_ready, k % 2);
      end
      step(k % 2);
      n_checks++;
      if ({rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata} !== {exp_rv0, exp_rd0, exp_rv1, exp_rd1}) begin
        n_fail++;
        $display("FAIL contend_rsp_%0d: v0/d0/v1/d1=%b/%h/%b/%h expected %b/%h/%b/%h", k, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, exp_rv0, exp_rd0, exp_rv1, exp_rd1);
      end
    end
    idle();
  endtask

  task automatic test_random();
    int   g;
    logic hold0, hold1;
    logic exp_we;
    hold0 = 1'b0;
    hold1 = 1'b0;
    idle();
    for (int k = 0; k < 300; k++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_we    = 1'($urandom_range(0, 1));
        req0_addr  = AW'($urandom_range(0, 3));
        req0_wdata = DW'($urandom);
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_we    = 1'($urandom_range(0, 1));
        req1_addr  = AW'($urandom_range(0, 3));
        req1_wdata = DW'($urandom);
      end
      #1;
      g = pick(req0_valid, req1_valid, exp_last);
      exp_we = (g == 0) ? req0_we : (g == 1) ? req1_we : 1'b0;
      n_checks++;
      if ({req0_ready, req1_ready, mem_we} !== {g == 0, g == 1, exp_we}) begin
        n_fail++;
        $display("FAIL rand_grant_%0d: rdy0/rdy1/we=%b/%b/%b expected %b/%b/%b", k, req0_ready, req1_ready, mem_we, g == 0, g == 1, exp_we);
      end
      if (g == 0 && req0_we) begin
        n_checks++;
        if ({mem_wraddr, mem_wrdata} !== {req0_addr, req0_wdata}) begin
          n_fail++;
          $display("FAIL rand_wr0_%0d: wraddr/wrdata=%0d/%h expected %0d/%h", k, mem_wraddr, mem_wrdata, req0_addr, req0_wdata);
        end
      end else if (g == 1 && req1_we) begin
        n_checks++;
        if ({mem_wraddr, mem_wrdata} !== {req1_addr, req1_wdata}) begin
          n_fail++;
          $display("FAIL rand_wr1_%0d: wraddr/wrdata=%0d/%h expected %0d/%h", k, mem_wraddr, mem_wrdata, req1_addr, req1_wdata);
        end
      end else begin
        n_checks++;
        if (mem_addr !== ((g == 0) ? req0_addr : (g == 1) ? req1_addr : AW'(0))) begin
          n_fail++;
          $display("FAIL rand_addr_%0d: mem_addr=%0d grant=%0d", k, mem_addr, g);
        end
      end
      hold0 = req0_valid && (g != 0);
      hold1 = req1_valid && (g != 1);
      step(g);
      n_checks++;
      if ({rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata} !== {exp_rv0, exp_rd0, exp_rv1, exp_rd1}) begin
        n_fail++;
        $display("FAIL rand_rsp_%0d: v0/d0/v1/d1=%b/%h/%b/%h expected %b/%h/%b/%h", k, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, exp_rv0, exp_rd0, exp_rv1, exp_rd1);
      end
    end
    idle();
  endtask

  task automatic test_clr();
    int g;
    idle();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = AW'(7); req0_wdata = DW'(4'hF);
    #1;
    step(pick(req0_valid, req1_valid, exp_last));
    idle();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = AW'(8); req1_wdata = DW'(4'h5);
    #1;
    step(pick(req0_valid, req1_valid, exp_last));
    idle();
    req0_valid = 1'b1; req0_addr = AW'(8);
    #1;
    step(pick(req0_valid, req1_valid, exp_last));
    clr = 1'b1;
    req0_addr = AW'(7);
    req1_valid = 1'b1; req1_addr = AW'(8);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready, busy, mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL clr_cycle: rdy0/rdy1/busy/we=%b/%b/%b/%b expected 0/0/0/0", req0_ready, req1_ready, busy, mem_we);
    end
    n_checks++;
    if ({rsp0_valid, rsp0_rdata} !== {1'b1, DW'(4'h5)}) begin
      n_fail++;
      $display("FAIL clr_rsp: v/d=%b/%h expected 1/5", rsp0_valid, rsp0_rdata);
    end
    step(-1);
    clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if ({busy, mem_we, mem_wraddr, mem_wrdata, req0_ready, req1_ready} !== {1'b1, 1'b1, AW'(i), DW'(0), 2'b00}) begin
        n_fail++;
        $display("FAIL clr_fill_%0d: busy/we/wraddr/wrdata/rdy=%b/%b/%0d/%0d/%b%b expected 1/1/%0d/0/00", i, busy, mem_we, mem_wraddr, mem_wrdata, req0_ready, req1_ready, i);
      end
      exp_mem[i] = '0;
      step(-1);
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      g = pick(req0_valid, req1_valid, exp_last);
      n_checks++;
      if ({busy, req0_ready, req1_ready} !== {1'b0, g == 0, g == 1}) begin
        n_fail++;
        $display("FAIL clr_after_%0d: busy/rdy0/rdy1=%b/%b/%b expected 0/%b/%b", k, busy, req0_ready, req1_ready, g == 0, g == 1);
      end
      step(g);
      if (g == 0) req0_valid = 1'b0;
      if (g == 1) req1_valid = 1'b0;
      n_checks++;
      if ({rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata} !== {exp_rv0, exp_rd0, exp_rv1, exp_rd1}) begin
        n_fail++;
        $display("FAIL clr_readback_%0d: v0/d0/v1/d1=%b/%h/%b/%h expected %b/%h/%b/%h", k, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, exp_rv0, exp_rd0, exp_rv1, exp_rd1);
      end
    end
    idle();
  endtask

  task automatic test_rst_midfill();
    int busy_cycles;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) step(-1);
    #1;
    n_checks++;
    if ({mem_we, mem_wraddr} !== {1'b1, AW'(7)}) begin
      n_fail++;
      $display("FAIL midfill_cnt: we/wraddr=%b/%0d expected 1/7", mem_we, mem_wraddr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, mem_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL midfill_rst: busy/we=%b/%b expected 1/0", busy, mem_we);
    end
    tick();
    rst = 1'b0;
    model_reset();
    busy_cycles = 0;
    while (busy_cycles < 40) begin
      #1;
      if (!busy) break;
      n_checks++;
      if ({mem_we, mem_wraddr} !== {1'b1, AW'(busy_cycles)}) begin
        n_fail++;
        $display("FAIL refill_%0d: we/wraddr=%b/%0d expected 1/%0d", busy_cycles, mem_we, mem_wraddr, busy_cycles % DEPTH);
      end
      busy_cycles++;
      step(-1);
    end
    n_checks++;
    if (busy_cycles != 16) begin
      n_fail++;
      $display("FAIL refill_len: busy cycles=%0d expected 16", busy_cycles);
    end
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata} !== '0) begin
      n_fail++;
      $display("FAIL refill_rsp: v0/v1/d0/d1=%b/%b/%h/%h expected all 0", rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_random();
    test_clr();
    test_rst_midfill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
